// File: rtl/gate_pkg.sv
// gate_pkg: function-select codes, FSM encoding and the expected-output helper shared by gate_exerciser.
package gate_pkg;
  localparam logic [1:0] FUNC_OR  = 2'd0;
  localparam logic [1:0] FUNC_AND = 2'd1;
  localparam logic [1:0] FUNC_XOR = 2'd2;
  localparam logic [1:0] FUNC_NOR = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_e;
  function automatic logic gate_expect(input logic [1:0] func, input logic a, input logic b);
    return func == FUNC_OR  ? a | b :
           func == FUNC_AND ? a & b :
           func == FUNC_XOR ? a ^ b : ~(a | b);
  endfunction
endpackage

// File: rtl/gate_exerciser_sync.sv
// sync_bit: STAGES-deep flop chain bringing an asynchronous bit into the clk domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk)
    sync_q <= !rst_n ? '0 : {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: walks a two-input gate through its truth table and reports per-vector mismatches.
// Define ERR_COUNT_EN to add a saturating lifetime mismatch counter on err_cnt.
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] func_sel,
  output logic       drv_a,
  output logic       drv_b,
  input  logic       gate_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);
  state_e     state_q;
  logic [1:0] idx_q;
  logic [1:0] func_q;
  logic [7:0] cnt_q;
  logic       c_s;
  logic       miss;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (gate_c),
    .q_o  (c_s)
  );
  assign miss = c_s != gate_expect(func_q, idx_q[1], idx_q[0]);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      func_q   <= '0;
      cnt_q    <= '0;
      drv_a    <= 1'b0;
      drv_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q        <= SETTLE;
          idx_q          <= '0;
          cnt_q          <= '0;
          fail_vec       <= '0;
          pass           <= 1'b0;
          func_q         <= func_sel;
          {drv_a, drv_b} <= 2'b00;
          busy           <= 1'b1;
        end
        SETTLE: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_q <= SAMPLE;
        end
        SAMPLE: begin
          fail_vec[idx_q] <= miss;
          if (idx_q == 2'd3) begin
            // pass must see this final vector's result, which is not in fail_vec yet
            state_q        <= DONE;
            done           <= 1'b1;
            pass           <= ~(|fail_vec[2:0] | miss);
            busy           <= 1'b0;
            {drv_a, drv_b} <= 2'b00;
          end else begin
            state_q        <= SETTLE;
            idx_q          <= idx_q + 2'd1;
            {drv_a, drv_b} <= idx_q + 2'd1;
            cnt_q          <= '0;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
`ifdef ERR_COUNT_EN
  always_ff @(posedge clk)
    if (!rst_n) err_cnt <= '0;
    else if (state_q == SAMPLE && miss && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: directed runs against a cycle-offset model of the exerciser's visible behaviour.
module tb_gate_exerciser;
  localparam int S = 4;
  localparam int VL = S + 1;
  localparam int RUN = 4 * VL;
  logic clk = 1'b0;
  logic rst_n, start, start3;
  logic [1:0] func_sel;
  logic drv_a, drv_b, gate_c, busy, done, pass;
  logic [3:0] fail_vec;
  logic drv_a3, drv_b3, gate_c3, busy3, done3, pass3;
  logic [3:0] fail_vec3;
`ifdef ERR_COUNT_EN
  logic [7:0] err_cnt, err_cnt3;
`endif
  logic stuck;
  int checks = 0, errors = 0, cyc = 0;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign gate_c = stuck ? 1'b1 : (drv_a | drv_b);
  // OR gate whose output lags its inputs by just under two clock periods
  assign #18 gate_c3 = drv_a3 | drv_b3;
  gate_exerciser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .drv_a(drv_a), .drv_b(drv_b), .gate_c(gate_c), .busy(busy), .done(done),
    .pass(pass), .fail_vec(fail_vec)
`ifdef ERR_COUNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  gate_exerciser #(.SETTLE_CYCLES(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .func_sel(2'd0),
    .drv_a(drv_a3), .drv_b(drv_b3), .gate_c(gate_c3), .busy(busy3), .done(done3),
    .pass(pass3), .fail_vec(fail_vec3)
`ifdef ERR_COUNT_EN
    , .err_cnt(err_cnt3)
`endif
  );
  // Model: ph = edges since the start edge; -1 after reset, RUN+1 once idle again.
  int ph = -1;
  int m_err = 0;
  logic [3:0] m_fail = '0;
  function automatic logic [3:0] func_tt(input logic [1:0] f);
    return f == 2'd0 ? 4'b1110 : f == 2'd1 ? 4'b1000 : f == 2'd2 ? 4'b0110 : 4'b0001;
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      ph = -1;
      m_fail = '0;
      m_err = 0;
    end else if ((ph < 0 || ph > RUN) && start) begin
      ph = 0;
      m_fail = (stuck ? 4'b1111 : 4'b1110) ^ func_tt(func_sel);
    end else if (ph >= 0 && ph <= RUN) begin
      ph++;
      if (ph % VL == 0 && ph <= RUN && m_err < 255) m_err += int'(m_fail[ph / VL - 1]);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    logic run_on;
    int vec;
    logic [3:0] mask;
    run_on = ph >= 0 && ph < RUN;
    vec = run_on ? ph / VL : 0;
    mask = '0;
    for (int v = 0; v < 4; v++) if (ph >= (v + 1) * VL) mask[v] = 1'b1;
    chk("busy", int'(busy), int'(run_on));
    chk("done", int'(done), int'(ph == RUN));
    chk("drv_a", int'(drv_a), vec / 2);
    chk("drv_b", int'(drv_b), vec % 2);
    chk("fail_vec", int'(fail_vec), int'(m_fail & mask));
    chk("pass", int'(pass), int'(ph >= RUN && m_fail == 4'b0000));
`ifdef ERR_COUNT_EN
    chk("err_cnt", int'(err_cnt), m_err);
`endif
  end
  task automatic run(input logic [1:0] f, input int restart_at, output int done_cyc, output int ndone);
    int c0;
    @(negedge clk);
    func_sel = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    done_cyc = -1;
    ndone = 0;
    for (int n = 1; n <= 30; n++) begin
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc - c0 + 1;
      end
      start = (n == restart_at);
      func_sel = 2'(n);
      @(negedge clk);
    end
    start = 1'b0;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int dc, nd, c0;
    rst_n = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    func_sel = 2'd0;
    stuck = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("reset_fail_vec", int'(fail_vec), 0);
    run(2'd0, 0, dc, nd);
    chk("or_done_cycle", dc, 21);
    chk("or_done_count", nd, 1);
    chk("or_fail_vec", int'(fail_vec), 0);
    chk("or_pass", int'(pass), 1);
    run(2'd1, 0, dc, nd);
    chk("and_fail_vec", int'(fail_vec), 4'b0110);
    chk("and_pass", int'(pass), 0);
    pulse_reset();
    stuck = 1'b1;
    run(2'd2, 0, dc, nd);
    chk("xor_fail_vec", int'(fail_vec), 4'b1001);
    chk("xor_pass", int'(pass), 0);
`ifdef ERR_COUNT_EN
    chk("err_cnt_run1", int'(err_cnt), 2);
`endif
    run(2'd2, 0, dc, nd);
    chk("xor2_fail_vec", int'(fail_vec), 4'b1001);
`ifdef ERR_COUNT_EN
    chk("err_cnt_run2", int'(err_cnt), 4);
`endif
    stuck = 1'b0;
    @(negedge clk);
    func_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_drv", int'({drv_a, drv_b}), 0);
    chk("rst_fail_vec", int'(fail_vec), 0);
    nd = 0;
    repeat (25) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("rst_no_done", nd, 0);
    run(2'd0, 0, dc, nd);
    chk("post_rst_done_cycle", dc, 21);
    chk("post_rst_pass", int'(pass), 1);
    run(2'd0, 10, dc, nd);
    chk("restart_done_count", nd, 1);
    chk("restart_done_cycle", dc, 21);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    c0 = cyc;
    dc = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done3 && dc < 0) dc = cyc - c0 + 1;
      @(negedge clk);
    end
    chk("s3_done_cycle", dc, 17);
    chk("s3_pass", int'(pass3), 1);
    chk("s3_fail_vec", int'(fail_vec3), 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
